// File: rtl/display_source_scheduler.sv
// Arbitrates the shared 4-digit display between the timer, score and alert sources.
// Timer and score alternate on a fixed dwell; the alert preempts them and blinks.
module display_source_scheduler #(
  parameter int unsigned DWELL_CYCLES = 200_000_000,
  parameter int unsigned BLINK_CYCLES = 50_000_000,
  parameter logic [3:0]  BLANK_CODE   = 4'hF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  req,
  input  logic [15:0] data0,
  input  logic [15:0] data1,
  input  logic [15:0] data2,
  output logic [2:0]  grant,
  output logic [3:0]  min_dig2,
  output logic [3:0]  min_dig1,
  output logic [3:0]  sec_dig2,
  output logic [3:0]  sec_dig1,
  output logic        owner_change
);

  localparam int unsigned DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam int unsigned BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [15:0] BLANK_WORD = {4{BLANK_CODE}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHOW  = 2'd1,
    ST_ALERT = 2'd2
  } state_t;

  state_t          r_state;
  logic            r_owner;
  logic            r_last_rr;
  logic [DW-1:0]   r_dwell_cnt;
  logic [BW-1:0]   r_blink_cnt;
  logic            r_blank;

  state_t          w_state_nx;
  logic            w_owner_nx;
  logic            w_last_rr_nx;
  logic [DW-1:0]   w_dwell_nx;
  logic [BW-1:0]   w_blink_nx;
  logic            w_blank_nx;
  logic            w_own_req;
  logic            w_oth_req;
  logic            w_pick;
  logic [2:0]      w_grant_nx;
  logic [15:0]     w_word_nx;

  // Next-owner decision; counters default to zero so every entry/switch restarts them.
  always_comb begin
    w_state_nx   = r_state;
    w_owner_nx   = r_owner;
    w_last_rr_nx = r_last_rr;
    w_dwell_nx   = '0;
    w_blink_nx   = '0;
    w_blank_nx   = 1'b0;
    w_own_req    = r_owner ? req[1] : req[0];
    w_oth_req    = r_owner ? req[0] : req[1];
    w_pick       = (req[0] & req[1]) ? ~r_last_rr : req[1];

    unique case (r_state)
      ST_SHOW: begin
        if (req[2]) begin
          w_state_nx = ST_ALERT;
        end else if (!w_own_req) begin
          if (w_oth_req) begin
            w_owner_nx   = ~r_owner;
            w_last_rr_nx = r_owner;
          end else begin
            w_state_nx = ST_IDLE;
          end
        end else if (r_dwell_cnt == DW'(DWELL_CYCLES - 1)) begin
          if (w_oth_req) begin
            w_owner_nx   = ~r_owner;
            w_last_rr_nx = r_owner;
          end
        end else begin
          w_dwell_nx = r_dwell_cnt + DW'(1);
        end
      end
      ST_ALERT: begin
        if (req[2]) begin
          if (r_blink_cnt == BW'(BLINK_CYCLES - 1)) begin
            w_blank_nx = ~r_blank;
          end else begin
            w_blink_nx = r_blink_cnt + BW'(1);
            w_blank_nx = r_blank;
          end
        end else if (|req[1:0]) begin
          w_state_nx = ST_SHOW;
          w_owner_nx = w_pick;
        end else begin
          w_state_nx = ST_IDLE;
        end
      end
      default: begin
        if (req[2]) begin
          w_state_nx = ST_ALERT;
        end else if (|req[1:0]) begin
          w_state_nx = ST_SHOW;
          w_owner_nx = w_pick;
        end
      end
    endcase
  end

  // Output selection from the owner chosen for the coming cycle.
  always_comb begin
    w_grant_nx = 3'b000;
    w_word_nx  = BLANK_WORD;
    unique case (w_state_nx)
      ST_SHOW: begin
        w_grant_nx = w_owner_nx ? 3'b010 : 3'b001;
        w_word_nx  = w_owner_nx ? data1 : data0;
      end
      ST_ALERT: begin
        w_grant_nx = 3'b100;
        w_word_nx  = w_blank_nx ? BLANK_WORD : data2;
      end
      default: begin
        w_grant_nx = 3'b000;
        w_word_nx  = BLANK_WORD;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_owner      <= 1'b0;
      r_last_rr    <= 1'b1;
      r_dwell_cnt  <= '0;
      r_blink_cnt  <= '0;
      r_blank      <= 1'b0;
      grant        <= 3'b000;
      min_dig2     <= BLANK_CODE;
      min_dig1     <= BLANK_CODE;
      sec_dig2     <= BLANK_CODE;
      sec_dig1     <= BLANK_CODE;
      owner_change <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_owner      <= w_owner_nx;
      r_last_rr    <= w_last_rr_nx;
      r_dwell_cnt  <= w_dwell_nx;
      r_blink_cnt  <= w_blink_nx;
      r_blank      <= w_blank_nx;
      grant        <= w_grant_nx;
      min_dig2     <= w_word_nx[15:12];
      min_dig1     <= w_word_nx[11:8];
      sec_dig2     <= w_word_nx[7:4];
      sec_dig1     <= w_word_nx[3:0];
      owner_change <= (w_grant_nx != grant);
    end
  end

endmodule
